// File: rtl/tausworthe_stream.sv
// taus88 combined Tausworthe generator. It supports runtime seed loading with sanitisation,
// discards a warm-up run of words, and emits OUT_W-bit words on a valid/ready stream.
module tausworthe_stream #(
  parameter logic [31:0] SEED1  = 32'hE761B9DB,
  parameter logic [31:0] SEED2  = 32'hB4B4D15C,
  parameter logic [31:0] SEED3  = 32'hC0B4DD55,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned WARMUP = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_seed_load,
  input  logic [95:0]      i_seed_in,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_word_cnt
);

  if (OUT_W != 32 && OUT_W != 64) begin : g_bad_out_w
    $error("tausworthe_stream: OUT_W must be 32 or 64");
  end

  typedef enum logic [0:0] {StWarm, StRun} state_e;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);
  localparam state_e     ST_INIT   = (WARMUP == 0) ? StRun : StWarm;

  // One taus88 step on the packed state {s3, s2, s1}.
  function automatic logic [95:0] taus_step(input logic [95:0] s);
    logic [31:0] a, b, c;
    a = s[31:0];
    b = s[63:32];
    c = s[95:64];
    a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
    b = ((b & 32'hFFFFFFF8) << 4) ^ (((b << 2) ^ b) >> 25);
    c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3) ^ c) >> 11);
    return {c, b, a};
  endfunction

  state_e           r_state, w_state_nxt;
  logic [95:0]      r_s, w_s_nxt;
  logic [7:0]       r_warm_cnt, w_warm_cnt_nxt;
  logic [OUT_W-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [CNT_W-1:0] r_word_cnt, w_word_cnt_nxt;

  logic [95:0]      w_st1, w_next, w_seed;
  logic [31:0]      w_draw1;
  logic [OUT_W-1:0] w_word;

  assign w_st1   = taus_step(r_s);
  assign w_draw1 = w_st1[31:0] ^ w_st1[63:32] ^ w_st1[95:64];

  if (OUT_W == 64) begin : g_out64
    logic [95:0] w_st2;
    logic [31:0] w_draw2;
    assign w_st2   = taus_step(w_st1);
    assign w_draw2 = w_st2[31:0] ^ w_st2[63:32] ^ w_st2[95:64];
    assign w_word  = {w_draw2, w_draw1};
    assign w_next  = w_st2;
  end else begin : g_out32
    assign w_word = w_draw1;
    assign w_next = w_st1;
  end

  // Seeds that would lock a component into its all-zero cycle fall back to the defaults.
  assign w_seed = {
    (i_seed_in[95:68] == '0) ? SEED3 : i_seed_in[95:64],
    (i_seed_in[63:35] == '0) ? SEED2 : i_seed_in[63:32],
    (i_seed_in[31:1]  == '0) ? SEED1 : i_seed_in[31:0]
  };

  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_warm_cnt_nxt  = r_warm_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_word_cnt_nxt  = r_word_cnt;
    if (i_seed_load) begin
      w_s_nxt         = w_seed;
      w_warm_cnt_nxt  = WARM_INIT;
      w_state_nxt     = ST_INIT;
      w_out_valid_nxt = 1'b0;
      w_word_cnt_nxt  = '0;
    end else begin
      if (r_out_valid && i_out_ready) begin
        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
      end
      unique case (r_state)
        StWarm: begin
          w_s_nxt        = w_next;
          w_warm_cnt_nxt = r_warm_cnt - 8'd1;
          if (r_warm_cnt == 8'd1) begin
            w_state_nxt = StRun;
          end
        end
        StRun: begin
          if (!r_out_valid || i_out_ready) begin
            w_out_data_nxt  = w_word;
            w_s_nxt         = w_next;
            w_out_valid_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_INIT;
      r_s         <= {SEED3, SEED2, SEED1};
      r_warm_cnt  <= WARM_INIT;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_warm_cnt  <= w_warm_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state == StWarm);
  assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_tausworthe_stream.sv
// Bench for tausworthe_stream: three configurations (no warm-up, warm-up 8, 64-bit words)
// checked against a draw-list reference model of the taus88 generator.
module tb_tausworthe_stream;
  localparam int WARM = 8;
  localparam int NGEN = 1200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [95:0] seed_in = '0;
  logic        out_ready = 1'b0;

  logic [31:0] o0_data, o0_cnt, o8_data, o8_cnt;
  logic        o0_valid, o0_busy, o8_valid, o8_busy;
  logic [63:0] o64_data;
  logic        o64_valid, o64_busy;
  logic [3:0]  o64_cnt;

  always #5 clk = ~clk;

  tausworthe_stream #(.WARMUP(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed_in(seed_in),
    .i_out_ready(out_ready), .o_out_data(o0_data), .o_out_valid(o0_valid),
    .o_busy(o0_busy), .o_word_cnt(o0_cnt)
  );
  tausworthe_stream #(.WARMUP(WARM)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed_in(seed_in),
    .i_out_ready(out_ready), .o_out_data(o8_data), .o_out_valid(o8_valid),
    .o_busy(o8_busy), .o_word_cnt(o8_cnt)
  );
  tausworthe_stream #(.OUT_W(64), .WARMUP(WARM), .CNT_W(4)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed_in(seed_in),
    .i_out_ready(out_ready), .o_out_data(o64_data), .o_out_valid(o64_valid),
    .o_busy(o64_busy), .o_word_cnt(o64_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] gen_q[$];
  logic [31:0] d_q[$];   // draws from the default seeds
  logic [31:0] m_q[$];   // draws from dut8's current seeds
  logic        m_valid;
  logic [31:0] m_data;
  int          m_warm, m_pos, m_cnt;

  task automatic gen(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    gen_q.delete();
    for (int i = 0; i < NGEN; i++) begin
      a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
      b = ((b & 32'hFFFFFFF8) << 4) ^ (((b << 2) ^ b) >> 25);
      c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3) ^ c) >> 11);
      gen_q.push_back(a ^ b ^ c);
    end
  endtask

  function automatic logic [31:0] pick(logic [31:0] v, logic [31:0] lim, logic [31:0] dflt);
    return (v < lim) ? dflt : v;
  endfunction

  // One clock edge; the dut8 model follows the inputs that were applied before the edge.
  task automatic tick();
    logic        rdy, ld;
    logic [95:0] sd;
    rdy = out_ready;
    ld  = seed_load;
    sd  = seed_in;
    @(posedge clk);
    #1;
    if (ld) begin
      gen(pick(sd[31:0], 2, 32'hE761B9DB), pick(sd[63:32], 8, 32'hB4B4D15C),
          pick(sd[95:64], 16, 32'hC0B4DD55));
      m_q = gen_q;
      m_valid = 1'b0;
      m_warm = WARM;
      m_pos = 0;
      m_cnt = 0;
    end else if (m_warm > 0) begin
      m_warm--;
      m_pos++;
    end else begin
      if (m_valid && rdy) m_cnt++;
      if (!m_valid || rdy) begin
        m_data = m_q[m_pos];
        m_pos++;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_q = d_q;
    m_valid = 1'b0;
    m_data = '0;
    m_warm = WARM;
    m_pos = 0;
    m_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({o8_valid, o8_busy, o8_data, o8_cnt} !== {1'b0, 1'b1, 64'h0})
      $display("FAIL reset_dut8: got v=%b b=%b d=%h c=%0d expected v=0 b=1 d=0 c=0",
               o8_valid, o8_busy, o8_data, o8_cnt);
    else n_pass++;
    n_total++;
    if ({o0_valid, o0_busy, o0_cnt} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL reset_dut0: got v=%b b=%b c=%0d expected v=0 b=0 c=0",
               o0_valid, o0_busy, o0_cnt);
    else n_pass++;
    n_total++;
    if ({o64_valid, o64_data, o64_cnt} !== 69'h0)
      $display("FAIL reset_dut64: got v=%b d=%h c=%0d expected all zero",
               o64_valid, o64_data, o64_cnt);
    else n_pass++;
  endtask

  task automatic test_warmup0_stream();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 1001; k++) begin
      tick();
      n_total++;
      if ({o0_valid, o0_data} !== {1'b1, d_q[k-1]})
        $display("FAIL w0_word%0d: got v=%b d=%h expected v=1 d=%h", k, o0_valid, o0_data,
                 d_q[k-1]);
      else n_pass++;
    end
    n_total++;
    if (o0_cnt !== 32'd1000) $display("FAIL w0_cnt: got %0d expected 1000", o0_cnt);
    else n_pass++;
  endtask

  task automatic test_warmup();
    do_reset();
    out_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_total++;
      if ({o8_busy, o8_valid} !== {(m_warm != 0), m_valid})
        $display("FAIL warm_edge%0d: got b=%b v=%b expected b=%b v=%b", e, o8_busy, o8_valid,
                 (m_warm != 0), m_valid);
      else n_pass++;
      if (e == 9) begin
        n_total++;
        if ({o8_valid, o8_data} !== {1'b1, d_q[8]})
          $display("FAIL warm_first: got v=%b d=%h expected v=1 d=%h", o8_valid, o8_data,
                   d_q[8]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_d, snap_c;
    repeat (3) tick();
    out_ready = 1'b0;
    snap_d = o8_data;
    snap_c = o8_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({o8_valid, o8_data, o8_cnt} !== {1'b1, snap_d, snap_c})
        $display("FAIL bp_hold%0d: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d", i, o8_valid,
                 o8_data, o8_cnt, snap_d, snap_c);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if ({o8_valid, o8_data, o8_cnt} !== {m_valid, m_data, 32'(m_cnt)})
        $display("FAIL bp_resume%0d: got v=%b d=%h c=%0d expected v=%b d=%h c=%0d", i,
                 o8_valid, o8_data, o8_cnt, m_valid, m_data, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_illegal_seed();
    logic [31:0] old_d;
    old_d = o8_data;
    seed_in = {32'h0000000F, 32'h00000007, 32'h00000001};
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_total++;
    if ({o8_valid, o8_busy, o8_data, o8_cnt} !== {1'b0, 1'b1, old_d, 32'h0})
      $display("FAIL ill_load: got v=%b b=%b d=%h c=%0d expected v=0 b=1 d=%h c=0",
               o8_valid, o8_busy, o8_data, o8_cnt, old_d);
    else n_pass++;
    repeat (9) tick();
    n_total++;
    if ({o8_valid, o8_data, o8_cnt} !== {1'b1, d_q[8], 32'h0})
      $display("FAIL ill_first: got v=%b d=%h c=%0d expected v=1 d=%h c=0", o8_valid,
               o8_data, o8_cnt, d_q[8]);
    else n_pass++;
    tick();
    n_total++;
    if ({o8_data, o8_cnt} !== {d_q[9], 32'h1})
      $display("FAIL ill_second: got d=%h c=%0d expected d=%h c=1", o8_data, o8_cnt, d_q[9]);
    else n_pass++;
  endtask

  task automatic test_seed_midwarm();
    do_reset();
    out_ready = 1'b1;
    repeat (2) tick();
    seed_in = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      n_total++;
      if ({o8_busy, o8_valid, o8_cnt} !== {(m_warm != 0), m_valid, 32'(m_cnt)} ||
          (m_valid && o8_data !== m_data))
        $display("FAIL midwarm%0d: got b=%b v=%b d=%h c=%0d expected b=%b v=%b d=%h c=%0d", e,
                 o8_busy, o8_valid, o8_data, o8_cnt, (m_warm != 0), m_valid, m_data, m_cnt);
      else n_pass++;
      if (e == 8 || e == 9) begin
        n_total++;
        if (o8_valid !== (e == 9))
          $display("FAIL midwarm_latency%0d: got v=%b expected %b", e, o8_valid, (e == 9));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_seeds();
    for (int it = 0; it < 4; it++) begin
      for (int p = 0; p < ((it == 1) ? 2 : 1); p++) begin
        for (int c = 0; c < 3; c++)
          seed_in[32*c +: 32] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : $urandom;
        seed_load = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      seed_load = 1'b0;
      for (int e = 0; e < 40; e++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n_total++;
        if ({o8_busy, o8_valid, o8_cnt} !== {(m_warm != 0), m_valid, 32'(m_cnt)} ||
            (m_valid && o8_data !== m_data))
          $display("FAIL rand%0d_%0d: got b=%b v=%b d=%h c=%0d expected b=%b v=%b d=%h c=%0d",
                   it, e, o8_busy, o8_valid, o8_data, o8_cnt, (m_warm != 0), m_valid, m_data,
                   m_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_out64();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      out_ready = 1'b1;
      for (int t = 1; t <= 28; t++) begin
        tick();
        if (t <= 8) begin
          n_total++;
          if (o64_valid !== 1'b0) $display("FAIL w64_warm%0d: got v=%b expected 0", t, o64_valid);
          else n_pass++;
        end else begin
          n_total++;
          if ({o64_valid, o64_data, o64_cnt} !==
              {1'b1, d_q[2*(t-1)+1], d_q[2*(t-1)], 4'(t-9)})
            $display("FAIL w64_word%0d: got v=%b d=%h c=%0d expected v=1 d=%h%h c=%0d", t,
                     o64_valid, o64_data, o64_cnt, d_q[2*(t-1)+1], d_q[2*(t-1)], 4'(t-9));
          else n_pass++;
        end
        if (pass == 1) break;
      end
      if (pass == 0) begin
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o64_valid, o64_data, o8_valid, o0_valid} !== 67'h0)
          $display("FAIL async_rst: got v64=%b d64=%h v8=%b v0=%b expected all zero",
                   o64_valid, o64_data, o8_valid, o0_valid);
        else n_pass++;
      end
    end
    repeat (8) tick();
    n_total++;
    if ({o64_valid, o64_data} !== {1'b1, d_q[17], d_q[16]})
      $display("FAIL w64_restart: got v=%b d=%h expected v=1 d=%h%h", o64_valid, o64_data,
               d_q[17], d_q[16]);
    else n_pass++;
  endtask

  initial begin
    gen(32'hE761B9DB, 32'hB4B4D15C, 32'hC0B4DD55);
    d_q = gen_q;
    test_reset();
    test_warmup0_stream();
    test_warmup();
    test_backpressure();
    test_illegal_seed();
    test_seed_midwarm();
    test_random_seeds();
    test_out64();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
